// File: rtl/tree_fanin_pkg.sv
// ----------------------------------------------------------------------------
// tree_fanin_pkg
//   Shared constants, width helpers and the beat record used by the upward
//   (child-to-parent) path of the instance tree.
//   - *_DEF localparams : default tree-node geometry
//   - src_width()       : width of a source index for n children (min 1)
//   - ptr_width()       : width of a FIFO read/write pointer (min 1)
//   - fanin_entry_t     : default-width beat record {last, src, data}
// ----------------------------------------------------------------------------
package tree_fanin_pkg;

  localparam int NUM_CHILDREN_DEF = 10;
  localparam int DATA_W_DEF       = 16;
  localparam int FIFO_DEPTH_DEF   = 4;

  // A single child still needs a one-bit source field.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int SRC_W_DEF = src_width(NUM_CHILDREN_DEF);

  typedef struct packed {
    logic                  last;
    logic [SRC_W_DEF-1:0]  src;
    logic [DATA_W_DEF-1:0] data;
  } fanin_entry_t;

endpackage

// File: rtl/tree_fanin_collector_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at ptr and wraps
//   from N-1 back to 0; the first requester found wins. N need not be a
//   power of two, so the wrap is done with an explicit compare.
//   Ports:
//     req       in  N      request vector
//     ptr       in  IDX_W  first index to consider (must be < N)
//     grant     out N      one-hot grant, or zero when nothing requests
//     grant_idx out IDX_W  index of the granted requester (0 when none)
//     any_grant out 1      some requester was granted
// ----------------------------------------------------------------------------
module rr_arbiter
  import tree_fanin_pkg::*;
#(
  parameter int N     = NUM_CHILDREN_DEF,
  parameter int IDX_W = src_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  // One extra bit so ptr + offset (< 2N) never overflows before the wrap.
  localparam logic [IDX_W:0] N_C = (IDX_W + 1)'(N);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional update; a path that leaves one unassigned infers a latch.
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (sum >= N_C) sum = sum - N_C;
      idx = sum[IDX_W-1:0];
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_fanin_collector.sv
// ----------------------------------------------------------------------------
// tree_fanin_collector
//   One node of the upward tree path: merges beats from NUM_CHILDREN children
//   into a single parent stream, tagging each beat with its source index.
//   A round-robin arbiter feeds a FIFO_DEPTH-entry output FIFO (no
//   fall-through, no bypass). Each child's "last" beat masks that child until
//   every child has delivered its last; the completing beat is tagged
//   parent_last and sweep_done pulses one cycle later.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     child_valid   per-child beat valid
//     child_last    per-child final-beat-of-sweep marker
//     child_data    packed payloads, child i at [i*DATA_W +: DATA_W]
//     child_ready   one-hot (or zero) accept strobe to the children
//     parent_valid  FIFO head valid
//     parent_data   FIFO head payload (0 when empty)
//     parent_src    FIFO head source index (0 when empty)
//     parent_last   FIFO head completed the sweep (0 when empty)
//     parent_ready  parent accepts the head
//     sweep_done    one-cycle pulse after the sweep-completing beat
// ----------------------------------------------------------------------------
module tree_fanin_collector
  import tree_fanin_pkg::*;
#(
  parameter  int NUM_CHILDREN = NUM_CHILDREN_DEF,
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  localparam int SRC_W        = src_width(NUM_CHILDREN)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        child_valid,
  input  logic [NUM_CHILDREN-1:0]        child_last,
  input  logic [NUM_CHILDREN*DATA_W-1:0] child_data,
  output logic [NUM_CHILDREN-1:0]        child_ready,
  output logic                           parent_valid,
  output logic [DATA_W-1:0]              parent_data,
  output logic [SRC_W-1:0]               parent_src,
  output logic                           parent_last,
  input  logic                           parent_ready,
  output logic                           sweep_done
);

  localparam int               PTR_W    = ptr_width(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_CHILDREN - 1);

  // Same layout as fanin_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              last;
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                  mem [FIFO_DEPTH];
  entry_t                  head;
  entry_t                  push_entry;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [SRC_W-1:0]        rr_ptr;
  logic [NUM_CHILDREN-1:0] last_seen;

  logic [NUM_CHILDREN-1:0] req, grant;
  logic [SRC_W-1:0]        grant_idx;
  logic                    any_grant;
  logic                    full, push, pop, push_last, sweep_end;
  logic [DATA_W-1:0]       push_data;

  // Children that already delivered their last beat sit out the rest of the
  // sweep. Nothing is granted while full or while reset is asserted, so
  // child_ready is zero in reset and a pop never makes room in the same cycle.
  assign full = (count == DEPTH_C);
  assign req  = child_valid & ~last_seen & {NUM_CHILDREN{~full & rst_n}};

  rr_arbiter #(
    .N     (NUM_CHILDREN),
    .IDX_W (SRC_W)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign child_ready = grant;
  assign push        = any_grant;
  assign push_last   = |(child_last & grant);
  // The accepted last beat is the one that fills in the final missing bit.
  assign sweep_end   = push_last & (&(last_seen | grant));

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (grant[i]) push_data = push_data | child_data[i*DATA_W +: DATA_W];
    end
  end

  assign push_entry = '{last: sweep_end, src: grant_idx, data: push_data};

  assign head         = mem[rd_ptr];
  assign parent_valid = (count != '0);
  assign parent_data  = parent_valid ? head.data : '0;
  assign parent_src   = parent_valid ? head.src  : '0;
  assign parent_last  = parent_valid ? head.last : 1'b0;
  assign pop          = parent_valid & parent_ready;

  // NOTE: the storage array has no reset; an empty FIFO never exposes it
  // because the head fields are masked by parent_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rr_ptr     <= '0;
      last_seen  <= '0;
      sweep_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (any_grant) rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + SRC_W'(1);

      // last_seen stays all-ones through the pulse cycle, then clears, so
      // masked children become eligible the cycle after sweep_done.
      if (sweep_done)     last_seen <= '0;
      else if (push_last) last_seen <= last_seen | grant;

      sweep_done <= sweep_end;
    end
  end

endmodule
